// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multi-cycle control unit and its datapath/memory.
// Memory handshake: during a memory-access state the controller holds its strobes
// steady; mem_ready=1 in a cycle means the access completes on that clock edge.
interface multicycle_ctrl_if;
  logic [31:0] instrucao;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDest;
  logic        RegWrite;
  logic [1:0]  MemToReg;
  logic        Jal_Dest;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        illegal_op;
  logic        mem_fault;
  logic [3:0]  state;

  modport master (
    input  instrucao, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDest, RegWrite,
           MemToReg, Jal_Dest, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, mem_fault, state
  );

  modport slave (
    output instrucao, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDest, RegWrite,
           MemToReg, Jal_Dest, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, mem_fault, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-wait timeout and sticky fault state.
// Optional feature: define CTRL_ADDI_EN to decode addi through IMMEX/IMMWB.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_IMMEX = 4'd11,
    S_IMMWB  = 4'd12, S_FAULT  = 4'd13
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dest;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       jal_dest;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write_u;
  } moore_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q;
  moore_t           out_q;
  logic             illegal;
  logic             wait_st;
  logic             timeout;
  logic             run;
  logic [5:0]       op;
  logic             unused_instr_bits;

  assign op                = bus.instrucao[31:26];
  assign unused_instr_bits = ^bus.instrucao[25:0];

  // State-only outputs, registered alongside the state they belong to.
  function automatic moore_t moore_out(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:  begin m.mem_read = 1'b1; m.alu_src_b = 2'b01; end
      S_DECODE: m.alu_src_b = 2'b11;
      S_MEMADR: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      S_MEMRD:  begin m.iord = 1'b1; m.mem_read = 1'b1; end
      S_MEMWB:  begin m.reg_write = 1'b1; m.mem_to_reg = 2'b01; end
      S_MEMWR:  begin m.iord = 1'b1; m.mem_write = 1'b1; end
      S_EXEC:   begin m.alu_src_a = 1'b1; m.alu_op = 2'b10; end
      S_ALUWB:  begin m.reg_dest = 1'b1; m.reg_write = 1'b1; end
      S_BRANCH: begin m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_source = 2'b01; end
      S_JUMP:   begin m.pc_source = 2'b10; m.pc_write_u = 1'b1; end
      S_JAL:    begin
        m.pc_source = 2'b10; m.pc_write_u = 1'b1; m.reg_write = 1'b1;
        m.mem_to_reg = 2'b10; m.jal_dest = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      S_IMMEX:  begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      S_IMMWB:  m.reg_write = 1'b1;
`endif
      default:  m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
`ifdef CTRL_ADDI_EN
          OP_ADDI:       state_d = S_IMMEX;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
`ifdef CTRL_ADDI_EN
      S_IMMEX:  state_d = S_IMMWB;
`endif
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase

    // A mem_ready in the timeout cycle takes priority: timeout requires !mem_ready.
    timeout = (TIMEOUT != 0) && wait_st && !bus.mem_ready && (cnt_q == CNT_W'(TIMEOUT));
    if (timeout) state_d = S_FAULT;

    if (!wait_st || bus.mem_ready || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != {CNT_W{1'b1}})                        cnt_d = cnt_q + 1'b1;
    else                                                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      out_q   <= moore_out(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= (state_d == S_FAULT);
      out_q   <= moore_out(state_d);
    end
  end

  // Reset masks every output so nothing strobes while the unit is being reset.
  assign run            = !reset;
  assign bus.PCWrite    = run & (((state_q == S_FETCH) & bus.mem_ready) |
                                 ((state_q == S_BRANCH) & bus.zero) | out_q.pc_write_u);
  assign bus.IRWrite    = run & (state_q == S_FETCH) & bus.mem_ready;
  assign bus.IorD       = run & out_q.iord;
  assign bus.MemRead    = run & out_q.mem_read;
  assign bus.MemWrite   = run & out_q.mem_write;
  assign bus.RegDest    = run & out_q.reg_dest;
  assign bus.RegWrite   = run & out_q.reg_write;
  assign bus.MemToReg   = {2{run}} & out_q.mem_to_reg;
  assign bus.Jal_Dest   = run & out_q.jal_dest;
  assign bus.ALUSrcA    = run & out_q.alu_src_a;
  assign bus.ALUSrcB    = {2{run}} & out_q.alu_src_b;
  assign bus.ALUOp      = {2{run}} & out_q.alu_op;
  assign bus.PCSource   = {2{run}} & out_q.pc_source;
  assign bus.illegal_op = run & illegal;
  assign bus.mem_fault  = run & fault_q;
  assign bus.state      = run ? state_q : 4'd0;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the MIPS datapath, and the successor to the single-cycle opcode decoder. A Moore/Mealy FSM steps each instruction through fetch, decode, execute, memory and write-back phases, one phase per clock, against a memory port with a ready handshake. It drives the shared-memory multi-cycle datapath: PC, IR, the register file, the ALU source muxes and the PC source mux. It adds a parametrised memory-wait timeout with a sticky fault state.

## Interface
Parameters:
- TIMEOUT, 255: max consecutive cycles waiting on mem_ready; 0 disables the timeout.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instrucao  in  32  IR contents; opcode = instrucao[31:26]; stable after FETCH completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC load enable, with the branch condition already folded in.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  IR load.
- RegDest  out  1  write-register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- MemToReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC.
- Jal_Dest  out  1  forces the write register to $31.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- mem_fault  out  1  sticky timeout flag.
- state  out  4  current state code, for debug.

## Operation
Every output not listed for a state is 0.

FSM states, with their outputs and transitions:
- 0 FETCH: MemRead=1, ALUSrcB=01. When mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE. Otherwise stay.
- 1 DECODE: ALUSrcB=11 (precomputes the branch target). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000 → IMMEX (only with the macro, see Configuration)
  - anything else → FETCH, with illegal_op=1 in this cycle.
- 2 MEMADR: ALUSrcA=1, ALUSrcB=10. Next MEMRD if the opcode is lw, else MEMWR.
- 3 MEMRD: IorD=1, MemRead=1. Next MEMWB on mem_ready, else stay.
- 4 MEMWB: RegWrite=1, MemToReg=01. Next FETCH.
- 5 MEMWR: IorD=1, MemWrite=1. Next FETCH on mem_ready, else stay.
- 6 EXEC: ALUSrcA=1, ALUOp=10. Next ALUWB.
- 7 ALUWB: RegDest=1, RegWrite=1. Next FETCH.
- 8 BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWrite=zero. Next FETCH.
- 9 JUMP: PCSource=10, PCWrite=1. Next FETCH.
- 10 JAL: PCSource=10, PCWrite=1, RegWrite=1, MemToReg=10, Jal_Dest=1. The PC already holds PC+4, so this writes the return address. Next FETCH.
- 11 IMMEX: ALUSrcA=1, ALUSrcB=10. Next IMMWB.
- 12 IMMWB: RegWrite=1, RegDest=0, MemToReg=00. Next FETCH.
- 13 FAULT: all strobes 0, mem_fault=1. Left only by reset.

Wait counter:
- Active only in the wait states FETCH, MEMRD and MEMWR.
- Cleared on every state change and whenever mem_ready=1.
- Otherwise increments each cycle, saturating at 2^CNT_W−1.
- If TIMEOUT≠0 and the counter equals TIMEOUT while mem_ready=0, the next state is FAULT.
- A mem_ready arriving in that same cycle wins: normal progress, no fault.

Opcode handling:
- The opcode is decoded combinationally from instrucao in DECODE and MEMADR.
- No copy of the opcode is latched, because the IR is frozen outside FETCH.

## Timing
- Reset (synchronous, sampled on the clk edge):
  - state ← FETCH, counter ← 0, mem_fault ← 0.
  - While reset=1, every output is forced to 0, including state=0.
  - First fetch strobe appears in the cycle after reset deasserts.
- Reset in any state, including FAULT or mid-wait, abandons the instruction; no write strobe is asserted in the reset cycle.
- Cycle counts with mem_ready tied high:
  - R-type 4, lw 5, sw 4, beq 3, j 3, jal 3, addi 4, illegal 2.
  - Each wait cycle adds 1.
- mem_ready is sampled only in wait states; it is ignored elsewhere.
- IRWrite and PCWrite in FETCH are combinational on mem_ready (Mealy); all other outputs depend only on state (Moore).
- A wait of exactly TIMEOUT cycles followed by mem_ready is not a fault. The fault is entered on the edge ending wait cycle TIMEOUT+1.

## Configuration
- Macro CTRL_ADDI_EN.
- Defined: opcode 001000 (addi) decodes to IMMEX → IMMWB.
- Undefined: IMMEX and IMMWB are not built; 001000 is treated as illegal (illegal_op pulse, return to FETCH). State codes 11 and 12 never appear.

## Test plan
- Reset held 3 cycles, then released, mem_ready=1, instrucao=0x00000020 (add): outputs all 0 during reset; state sequence 0,1,6,7,0; RegWrite=1 and RegDest=1 only in ALUWB.
- lw 0x8C000004 with mem_ready low for 2 cycles in MEMRD: state 3 held 3 cycles; MemToReg=01 and RegWrite=1 in MEMWB; total 7 cycles.
- beq 0x10000001 with zero=1, then again with zero=0: PCWrite=1 and PCSource=01 in state 8 for the first, PCWrite=0 for the second; both return to FETCH after 3 cycles.
- jal 0x0C000010: state 10 shows PCWrite=1, RegWrite=1, MemToReg=10, Jal_Dest=1.
- TIMEOUT=4, mem_ready held 0 in FETCH: state=13 and mem_fault=1 after 5 cycles and held there; a reset pulse returns state to 0 with mem_fault=0.
- Opcode 0x3F, and 001000 without CTRL_ADDI_EN: illegal_op=1 for exactly one cycle in DECODE, then FETCH.
